// File: rtl/btn_pkg.sv
// Register offsets, field positions and the byte-lane merge helper shared
// by the pushbutton debounce block.
package btn_pkg;

    localparam logic [3:0] BTN_STATE  = 4'h0;
    localparam logic [3:0] BTN_STATUS = 4'h1;
    localparam logic [3:0] BTN_IEN    = 4'h2;
    localparam logic [3:0] BTN_PERIOD = 4'h3;
    localparam logic [3:0] BTN_RAW    = 4'h4;

    localparam int BTN_REL_LSB = 16;

    // Expands the four byte enables into a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] sel_merge(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        return (cur & ~lane_mask(sel)) | (wdat & lane_mask(sel));
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One pushbutton: two-flop synchroniser, debounce counter, debounced level
// and single-cycle press/release pulses.
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int DBNC_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic [DBNC_W-1:0] thresh,
    output logic              sync,
    output logic              stable,
    output logic              press,
    output logic              rel
);

    logic              meta;
    logic [DBNC_W-1:0] cnt;
    logic              mismatch;
    logic              hit;

    // Compare with >= so a period shortened mid-count still terminates.
    assign mismatch = sync ^ stable;
    assign hit      = mismatch && (cnt >= thresh);
    assign press    = hit & sync;
    assign rel      = hit & ~sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= btn_raw;
            sync <= meta;
            if (!mismatch) begin
                cnt <= '0;
            end else if (hit) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DBNC_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_btn_debounce.sv
// Wishbone slave for the pushbutton window: debounced state, W1C event
// status, interrupt enables, debounce period and raw synchronised inputs.
module wb_btn_debounce
    import btn_pkg::*;
#(
    parameter int          NUM_BTN  = 5,
    parameter int          DBNC_W   = 20,
    parameter int unsigned DBNC_RST = 1000000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic               btn_irq_o
);

    localparam logic [31:0] LOW_MASK = 32'((33'd1 << NUM_BTN) - 33'd1);
    localparam logic [31:0] EVT_MASK = LOW_MASK | (LOW_MASK << BTN_REL_LSB);

    logic [NUM_BTN-1:0] sync;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] rel;

    logic [31:0]       status;
    logic [31:0]       ien;
    logic [DBNC_W-1:0] period;
    logic [DBNC_W-1:0] thresh;
    logic [DBNC_W-1:0] period_wr;

    logic        req;
    logic        wr_en;
    logic [3:0]  offs;
    logic [31:0] rd_data;
    logic [31:0] evt_set;
    logic [31:0] evt_clr;
    logic [31:0] status_next;
    logic        unused_bus;

    assign unused_bus = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_cti_i, wb_bte_i};

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    assign req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_en = req & wb_we_i;
    assign offs  = wb_adr_i[5:2];

    // A zero period behaves as one cycle.
    assign thresh    = (period == '0) ? '0 : period - DBNC_W'(1);
    assign period_wr = DBNC_W'(sel_merge(32'(period), wb_dat_i, wb_sel_i));

    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_cell
        btn_debounce_cell #(
            .DBNC_W (DBNC_W)
        ) u_cell (
            .clk     (wb_clk_i),
            .rst     (wb_rst_i),
            .btn_raw (btn_i[g]),
            .thresh  (thresh),
            .sync    (sync[g]),
            .stable  (stable[g]),
            .press   (press[g]),
            .rel     (rel[g])
        );
    end

    always_comb begin
        evt_set = '0;
        evt_set[NUM_BTN-1:0]               = press;
        evt_set[BTN_REL_LSB +: NUM_BTN]    = rel;
    end

    // New events win over a simultaneous clear of the same bit.
    assign evt_clr     = (wr_en && offs == BTN_STATUS) ? (wb_dat_i & lane_mask(wb_sel_i)) : '0;
    assign status_next = ((status & ~evt_clr) | evt_set) & EVT_MASK;

    always_comb begin
        rd_data = '0;
        case (offs)
            BTN_STATE:  rd_data = 32'(stable);
            BTN_STATUS: rd_data = status;
            BTN_IEN:    rd_data = ien;
            BTN_PERIOD: rd_data = 32'(period);
            BTN_RAW:    rd_data = 32'(sync);
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            btn_irq_o <= 1'b0;
            status    <= '0;
            ien       <= '0;
            period    <= DBNC_W'(DBNC_RST);
        end else begin
            wb_ack_o  <= req;
            if (req) begin
                wb_dat_o <= rd_data;
            end
            status    <= status_next;
            btn_irq_o <= |(status & ien);
            if (wr_en && offs == BTN_IEN) begin
                ien <= sel_merge(ien, wb_dat_i, wb_sel_i) & EVT_MASK;
            end
            if (wr_en && offs == BTN_PERIOD) begin
                period <= period_wr;
            end
        end
    end

endmodule
